// File: rtl/riscv_pkg.sv
// Shared CSR-path types: widths, Zicsr funct3, CSR bus commands,
// exception causes and the CSR access sequencer states.
package riscv_pkg;

  localparam int XLEN  = 64;
  localparam int MXLEN = 64;

  typedef enum logic [2:0] {
    CSR_RW  = 3'b001,
    CSR_RS  = 3'b010,
    CSR_RC  = 3'b011,
    CSR_RWI = 3'b101,
    CSR_RSI = 3'b110,
    CSR_RCI = 3'b111
  } csr_funct3_t;

  typedef enum logic [1:0] {
    CSR_NONE           = 2'd0,
    CSR_READ_ONLY      = 2'd1,
    CSR_WRITE_ONLY     = 2'd2,
    CSR_WRITE_AND_READ = 2'd3
  } csr_command_t;

  typedef enum logic [3:0] {
    CAUSE_NONE                = 4'd0,
    CAUSE_ILLEGAL_INSTRUCTION = 4'd2
  } csr_exception_cause_t;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    TRAP,
    RESP
  } csr_access_state_t;

  function automatic logic csr_is_read_only(input logic [11:0] addr);
    return addr[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/csr_access_unit_alu.sv
// Zicsr read-modify-write datapath: new CSR value and whether the
// instruction intends to write at all.
module csr_alu
  import riscv_pkg::*;
(
  input  csr_funct3_t      funct3,
  input  logic             rs1_is_x0,
  input  logic [MXLEN-1:0] old_value,
  input  logic [MXLEN-1:0] src,
  output logic [MXLEN-1:0] new_value,
  output logic             write_intent
);

  always_comb begin
    new_value    = old_value;
    write_intent = 1'b0;
    unique case (1'b1)
      (funct3 == CSR_RW) || (funct3 == CSR_RWI): begin
        new_value    = src;
        write_intent = 1'b1;
      end
      (funct3 == CSR_RS) || (funct3 == CSR_RSI): begin
        new_value    = old_value | src;
        write_intent = !rs1_is_x0;
      end
      (funct3 == CSR_RC) || (funct3 == CSR_RCI): begin
        new_value    = old_value & ~src;
        write_intent = !rs1_is_x0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/csr_access_unit.sv
// Core-side CSR initiator: IDLE -> READ -> WRITE/TRAP -> RESP.
// CSR_FAST_ACCESS_EN merges READ/WRITE into one WRITE_AND_READ access.
module csr_access_unit
  import riscv_pkg::*;
(
  input  logic                 clock_i,
  input  logic                 reset_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [2:0]           req_funct3_i,
  input  logic [11:0]          req_csr_address_i,
  input  logic [MXLEN-1:0]     req_rs1_data_i,
  input  logic [4:0]           req_zimm_i,
  input  logic                 req_rs1_is_x0_i,
  input  logic [XLEN-1:0]      req_pc_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [MXLEN-1:0]     rsp_rd_data_o,
  output logic                 rsp_illegal_o,
  output logic [11:0]          csr_address_o,
  output csr_command_t         csr_command_o,
  output logic [MXLEN-1:0]     csr_write_data_o,
  input  logic [MXLEN-1:0]     csr_read_data_i,
  input  logic                 csr_read_data_valid_i,
  output logic                 csr_exception_o,
  output csr_exception_cause_t csr_exception_cause_o,
  output logic [XLEN-1:0]      csr_exception_pc_o
);

  csr_access_state_t state, state_nxt;
  csr_funct3_t       funct3_r;
  logic [11:0]       addr_r;
  logic [MXLEN-1:0]  src_r;
  logic [MXLEN-1:0]  old_r;
  logic [XLEN-1:0]   pc_r;
  logic              x0_r;
  logic              illegal_r;

  logic [MXLEN-1:0]  alu_old;
  logic [MXLEN-1:0]  new_value;
  logic              write_intent;
  logic              ro_trap;
  logic              access_illegal;

`ifdef CSR_FAST_ACCESS_EN
  assign alu_old = csr_read_data_i;
`else
  assign alu_old = old_r;
`endif

  csr_alu u_alu (
    .funct3       (funct3_r),
    .rs1_is_x0    (x0_r),
    .old_value    (alu_old),
    .src          (src_r),
    .new_value    (new_value),
    .write_intent (write_intent)
  );

  assign ro_trap        = write_intent && csr_is_read_only(addr_r);
  assign access_illegal = ro_trap || !csr_read_data_valid_i;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state     <= IDLE;
      funct3_r  <= CSR_RW;
      addr_r    <= '0;
      src_r     <= '0;
      old_r     <= '0;
      pc_r      <= '0;
      x0_r      <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid_i) begin
        funct3_r  <= csr_funct3_t'(req_funct3_i);
        addr_r    <= req_csr_address_i;
        src_r     <= req_funct3_i[2]
                   ? {{(MXLEN-5){1'b0}}, req_zimm_i}
                   : req_rs1_data_i;
        pc_r      <= req_pc_i;
        x0_r      <= req_rs1_is_x0_i;
        old_r     <= '0;
        illegal_r <= 1'b0;
      end
      if (state == READ) begin
        old_r     <= csr_read_data_i;
        illegal_r <= access_illegal;
      end
    end
  end

  always_comb begin
    state_nxt             = state;
    req_ready_o           = 1'b0;
    rsp_valid_o           = 1'b0;
    rsp_rd_data_o         = '0;
    rsp_illegal_o         = 1'b0;
    csr_address_o         = '0;
    csr_command_o         = CSR_NONE;
    csr_write_data_o      = '0;
    csr_exception_o       = 1'b0;
    csr_exception_cause_o = CAUSE_NONE;
    csr_exception_pc_o    = '0;
    unique case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_nxt = READ;
      end
`ifdef CSR_FAST_ACCESS_EN
      READ: begin
        state_nxt = RESP;
        // read-only target is known from the address alone, so never issue
        if (!ro_trap) begin
          csr_address_o    = addr_r;
          csr_command_o    = write_intent ? CSR_WRITE_AND_READ
                                          : CSR_READ_ONLY;
          csr_write_data_o = write_intent ? new_value : '0;
        end
        if (access_illegal) begin
          csr_exception_o       = 1'b1;
          csr_exception_cause_o = CAUSE_ILLEGAL_INSTRUCTION;
          csr_exception_pc_o    = pc_r;
        end
      end
`else
      READ: begin
        csr_address_o = addr_r;
        csr_command_o = CSR_READ_ONLY;
        if (access_illegal)    state_nxt = TRAP;
        else if (write_intent) state_nxt = WRITE;
        else                   state_nxt = RESP;
      end
`endif
      WRITE: begin
        csr_address_o    = addr_r;
        csr_command_o    = CSR_WRITE_ONLY;
        csr_write_data_o = new_value;
        state_nxt        = RESP;
      end
      TRAP: begin
        csr_exception_o       = 1'b1;
        csr_exception_cause_o = CAUSE_ILLEGAL_INSTRUCTION;
        csr_exception_pc_o    = pc_r;
        state_nxt             = RESP;
      end
      RESP: begin
        rsp_valid_o   = 1'b1;
        rsp_rd_data_o = illegal_r ? '0 : old_r;
        rsp_illegal_o = illegal_r;
        if (rsp_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed + random bench for csr_access_unit with a small CSR
// handler and a map-based reference model of the CSR file.
module tb_csr_access_unit;
  import riscv_pkg::*;

  localparam logic [63:0] BOOT = 64'h0000_0000_8000_0000;

  logic                 clock_i;
  logic                 reset_ni;
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [2:0]           req_funct3_i;
  logic [11:0]          req_csr_address_i;
  logic [63:0]          req_rs1_data_i;
  logic [4:0]           req_zimm_i;
  logic                 req_rs1_is_x0_i;
  logic [63:0]          req_pc_i;
  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [63:0]          rsp_rd_data_o;
  logic                 rsp_illegal_o;
  logic [11:0]          csr_address_o;
  csr_command_t         csr_command_o;
  logic [63:0]          csr_write_data_o;
  logic [63:0]          csr_read_data_i;
  logic                 csr_read_data_valid_i;
  logic                 csr_exception_o;
  csr_exception_cause_t csr_exception_cause_o;
  logic [63:0]          csr_exception_pc_o;

  csr_access_unit dut (
    .clock_i               (clock_i),
    .reset_ni              (reset_ni),
    .req_valid_i           (req_valid_i),
    .req_ready_o           (req_ready_o),
    .req_funct3_i          (req_funct3_i),
    .req_csr_address_i     (req_csr_address_i),
    .req_rs1_data_i        (req_rs1_data_i),
    .req_zimm_i            (req_zimm_i),
    .req_rs1_is_x0_i       (req_rs1_is_x0_i),
    .req_pc_i              (req_pc_i),
    .rsp_valid_o           (rsp_valid_o),
    .rsp_ready_i           (rsp_ready_i),
    .rsp_rd_data_o         (rsp_rd_data_o),
    .rsp_illegal_o         (rsp_illegal_o),
    .csr_address_o         (csr_address_o),
    .csr_command_o         (csr_command_o),
    .csr_write_data_o      (csr_write_data_o),
    .csr_read_data_i       (csr_read_data_i),
    .csr_read_data_valid_i (csr_read_data_valid_i),
    .csr_exception_o       (csr_exception_o),
    .csr_exception_cause_o (csr_exception_cause_o),
    .csr_exception_pc_o    (csr_exception_pc_o)
  );

  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  // CSR handler: mscratch, mie, mtvec writable; mhartid read-only
  logic        h_init;
  logic [63:0] mscratch, mie, mtvec;
  logic        is_wr;

  assign is_wr = (csr_command_o == CSR_WRITE_ONLY)
              || (csr_command_o == CSR_WRITE_AND_READ);

  always_comb begin
    csr_read_data_i       = '0;
    csr_read_data_valid_i = 1'b0;
    if (csr_command_o != CSR_NONE) begin
      case (csr_address_o)
        12'h340: begin csr_read_data_i = mscratch; csr_read_data_valid_i = 1'b1; end
        12'h304: begin csr_read_data_i = mie;      csr_read_data_valid_i = 1'b1; end
        12'h305: begin csr_read_data_i = mtvec;    csr_read_data_valid_i = 1'b1; end
        12'hF14: begin csr_read_data_i = '0;       csr_read_data_valid_i = 1'b1; end
        default: ;
      endcase
    end
  end

  always @(posedge clock_i) begin
    if (h_init) begin
      mscratch <= '0;
      mie      <= '0;
      mtvec    <= BOOT;
    end else if (is_wr && csr_read_data_valid_i
                 && csr_address_o[11:10] != 2'b11) begin
      case (csr_address_o)
        12'h340: mscratch <= csr_write_data_o;
        12'h304: mie      <= csr_write_data_o;
        12'h305: mtvec    <= csr_write_data_o;
        default: ;
      endcase
    end
  end

  int          wr_cnt, bus_cnt, exc_cnt;
  logic [3:0]  last_cause;
  logic [63:0] last_pc;

  always @(posedge clock_i) begin
    if (is_wr) wr_cnt <= wr_cnt + 1;
    if (csr_command_o != CSR_NONE) bus_cnt <= bus_cnt + 1;
    if (csr_exception_o) begin
      exc_cnt    <= exc_cnt + 1;
      last_cause <= csr_exception_cause_o;
      last_pc    <= csr_exception_pc_o;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: architectural CSR contents by address
  logic [63:0] ref_csr [logic [11:0]];

  function automatic logic [63:0] hval(input logic [11:0] a);
    case (a)
      12'h340: return mscratch;
      12'h304: return mie;
      12'h305: return mtvec;
      default: return 64'd0;
    endcase
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 64'(req_ready_o), 64'd1);
    check({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'd0);
    check({tag, "_cmd"}, 64'(csr_command_o), 64'(CSR_NONE));
    check({tag, "_addr"}, 64'(csr_address_o), 64'd0);
    check({tag, "_wdata"}, csr_write_data_o, 64'd0);
    check({tag, "_exc"}, 64'(csr_exception_o), 64'd0);
    check({tag, "_rd"}, rsp_rd_data_o, 64'd0);
    check({tag, "_illegal"}, 64'(rsp_illegal_o), 64'd0);
  endtask

  task automatic do_op(input logic [2:0] f3, input logic [11:0] a,
                       input logic [63:0] rs1, input logic [4:0] zimm,
                       input logic x0, input logic [63:0] pc,
                       input int hold);
    logic        ex, intent, ill;
    logic [63:0] old, src, nv, exp_rd;
    int          lat, exp_lat, exp_bus, w0, e0, b0;
    ex     = ref_csr.exists(a);
    old    = ex ? ref_csr[a] : 64'd0;
    src    = f3[2] ? {59'd0, zimm} : rs1;
    intent = (f3[1:0] == 2'b01) || !x0;
    ill    = !ex || (intent && a[11:10] == 2'b11);
    case (f3[1:0])
      2'b01:   nv = src;
      2'b10:   nv = old | src;
      default: nv = old & ~src;
    endcase
    exp_rd = ill ? 64'd0 : old;
`ifdef CSR_FAST_ACCESS_EN
    exp_lat = 2;
    exp_bus = (intent && a[11:10] == 2'b11) ? 0 : 1;
`else
    exp_lat = (!ill && !intent) ? 2 : 3;
    exp_bus = (!ill && intent) ? 2 : 1;
`endif
    @(negedge clock_i);
    check("req_ready_idle", 64'(req_ready_o), 64'd1);
    w0 = wr_cnt; e0 = exc_cnt; b0 = bus_cnt;
    req_valid_i       = 1'b1;
    req_funct3_i      = f3;
    req_csr_address_i = a;
    req_rs1_data_i    = rs1;
    req_zimm_i        = zimm;
    req_rs1_is_x0_i   = x0;
    req_pc_i          = pc;
    @(posedge clock_i); #1;
    req_valid_i = 1'b0;
    lat = 1;
    while (!rsp_valid_o && lat < 10) begin
      check("ready_low_busy", 64'(req_ready_o), 64'd0);
      @(posedge clock_i); #1;
      lat++;
    end
    check("rsp_valid_seen", 64'(rsp_valid_o), 64'd1);
    check("latency", 64'(lat), 64'(exp_lat));
    check("rd_data", rsp_rd_data_o, exp_rd);
    check("illegal", 64'(rsp_illegal_o), 64'(ill));
    for (int i = 0; i < hold; i++) begin
      @(posedge clock_i); #1;
      check("hold_valid", 64'(rsp_valid_o), 64'd1);
      check("hold_rd", rsp_rd_data_o, exp_rd);
      check("hold_illegal", 64'(rsp_illegal_o), 64'(ill));
      check("hold_ready", 64'(req_ready_o), 64'd0);
    end
    rsp_ready_i = 1'b1;
    @(posedge clock_i); #1;
    rsp_ready_i = 1'b0;
    check("after_hs_ready", 64'(req_ready_o), 64'd1);
    check("after_hs_valid", 64'(rsp_valid_o), 64'd0);
    check("writes", 64'(wr_cnt - w0), 64'(!ill && intent));
    check("exceptions", 64'(exc_cnt - e0), 64'(ill));
    check("bus_traffic", 64'(bus_cnt - b0), 64'(exp_bus));
    if (ill) begin
      check("exc_cause", 64'(last_cause), 64'd2);
      check("exc_pc", last_pc, pc);
    end
    if (!ill && intent) ref_csr[a] = nv;
    if (ex && a != 12'hF14) check("csr_state", hval(a), ref_csr[a]);
  endtask

  initial begin
    logic [11:0] addrs [5];
    logic [2:0]  f3s [6];
    logic [2:0]  f3;
    logic [11:0] a;
    logic [4:0]  z;
    logic        x0;
    logic [63:0] r;
    int          w0;
    addrs = '{12'h340, 12'h304, 12'h305, 12'hF14, 12'h7C0};
    f3s   = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
    ref_csr[12'h340] = 64'd0;
    ref_csr[12'h304] = 64'd0;
    ref_csr[12'h305] = BOOT;
    ref_csr[12'hF14] = 64'd0;

    reset_ni = 1'b0; h_init = 1'b1;
    req_valid_i = 1'b0; req_funct3_i = '0; req_csr_address_i = '0;
    req_rs1_data_i = '0; req_zimm_i = '0; req_rs1_is_x0_i = 1'b0;
    req_pc_i = '0; rsp_ready_i = 1'b0;
    repeat (3) @(posedge clock_i);
    #1;
    check_idle_outputs("reset");
    @(negedge clock_i);
    reset_ni = 1'b1; h_init = 1'b0;

    // 1: mscratch write then read-back
    do_op(3'b001, 12'h340, 64'hDEAD_BEEF, 5'd0, 1'b0, 64'h1000, 0);
    do_op(3'b010, 12'h340, 64'd0, 5'd0, 1'b1, 64'h1004, 0);
    // 2: mie set then clear
    do_op(3'b010, 12'h304, 64'h888, 5'd0, 1'b0, 64'h1008, 0);
    do_op(3'b011, 12'h304, 64'h008, 5'd0, 1'b0, 64'h100C, 1);
    check("mie_final", mie, 64'h880);
    // 3: read-only access of mtvec
    do_op(3'b010, 12'h305, 64'd0, 5'd0, 1'b1, 64'h1010, 0);
    // 4: nonexistent CSR, and write to read-only mhartid
    do_op(3'b010, 12'h7C0, 64'd0, 5'd0, 1'b1, 64'h2000_0040, 0);
    do_op(3'b001, 12'hF14, 64'h55, 5'd0, 1'b0, 64'h2000_0044, 0);
    do_op(3'b110, 12'hF14, 64'd0, 5'd0, 1'b1, 64'h2000_0048, 0);
    // 5: writeback stall
    do_op(3'b101, 12'h340, 64'd0, 5'd17, 1'b0, 64'h1020, 5);

    // 6: reset during the WRITE cycle of mscratch=0x1234
    @(negedge clock_i);
    w0 = wr_cnt;
    req_valid_i = 1'b1; req_funct3_i = 3'b001;
    req_csr_address_i = 12'h340; req_rs1_data_i = 64'h1234;
    req_rs1_is_x0_i = 1'b0; req_pc_i = 64'h3000;
    @(posedge clock_i); #1;
    req_valid_i = 1'b0;
    @(posedge clock_i); #1;
    check("pre_reset_cmd", 64'(csr_command_o), 64'(CSR_WRITE_ONLY));
    reset_ni = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    @(posedge clock_i); #1;
    check("reset_no_commit", mscratch, ref_csr[12'h340]);
    check("reset_no_write", 64'(wr_cnt - w0), 64'd0);
    @(negedge clock_i);
    reset_ni = 1'b1;
    do_op(3'b010, 12'h340, 64'd0, 5'd0, 1'b1, 64'h3004, 0);

    // randomized traffic against the reference model
    for (int n = 0; n < 60; n++) begin
      a  = addrs[$urandom_range(0, 4)];
      f3 = f3s[$urandom_range(0, 5)];
      z  = 5'($urandom_range(0, 31));
      if (f3[2]) begin
        x0 = (z == 5'd0);
        r  = {$urandom, $urandom};
      end else begin
        x0 = ($urandom_range(0, 3) == 0);
        r  = x0 ? 64'd0 : {$urandom, $urandom};
      end
      do_op(f3, a, r, z, x0, {$urandom, $urandom} & ~64'd3,
            $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
